// File: rtl/csr_file_hpm.sv
// Machine-mode CSR file with trap/mret, interrupts and NUM_HPM event counters; CSR_VECTORED_MTVEC_EN enables vectored mtvec.
// Latency: reads combinational, updates at the next clk_i edge; mip lags the irq lines by 1 cycle; no backpressure.
module csr_file_hpm #(
    parameter int NUM_HPM   = 4,
    parameter int HPM_WIDTH = 40
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  csr_req_i,
    input  logic [11:0]                           csr_addr_i,
    input  logic [1:0]                            csr_wtype_i,
    input  logic [31:0]                           csr_woperand_i,
    output logic [31:0]                           csr_rdata_o,
    output logic                                  csr_illegal_o,
    input  logic                                  retire_i,
    input  logic                                  trap_valid_i,
    input  logic                                  trap_is_irq_i,
    input  logic [30:0]                           trap_cause_i,
    input  logic [31:0]                           trap_pc_i,
    input  logic [31:0]                           trap_tval_i,
    input  logic                                  mret_i,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
    input  logic                                  irq_ext_i,
    input  logic                                  irq_timer_i,
    input  logic                                  irq_soft_i,
    output logic                                  irq_req_o,
    output logic [30:0]                           irq_cause_o,
    output logic [31:0]                           trap_handler_addr_o,
    output logic [31:0]                           mepc_o
);
    localparam int          HPMN      = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [63:0] HPM_MASK  = (HPM_WIDTH >= 64) ? {64{1'b1}} : ((64'd1 << HPM_WIDTH) - 64'd1);
    localparam logic [63:0] INH_HPM64 = ((64'd1 << NUM_HPM) - 64'd1) << 3;
    localparam logic [31:0] INH_MASK  = 32'h0000_0005 | INH_HPM64[31:0];
`ifdef CSR_VECTORED_MTVEC_EN
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_inhibit;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_mip;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic [63:0] w_hpm [HPMN];

    logic        w_hit;
    logic [31:0] w_rdata;
    logic [31:0] w_wdata;
    logic        w_we;
    logic [31:0] w_pend;

    always_comb begin
        w_rdata = 32'd0;
        w_hit   = 1'b1;
        case (csr_addr_i)
            12'h300: w_rdata = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
            12'h304: w_rdata = r_mie;
            12'h305: w_rdata = r_mtvec;
            12'h320: w_rdata = r_inhibit;
            12'h340: w_rdata = r_mscratch;
            12'h341: w_rdata = r_mepc;
            12'h342: w_rdata = r_mcause;
            12'h343: w_rdata = r_mtval;
            12'h344: w_rdata = r_mip;
            12'hB00: w_rdata = r_mcycle[31:0];
            12'hB80: w_rdata = r_mcycle[63:32];
            12'hB02: w_rdata = r_minstret[31:0];
            12'hB82: w_rdata = r_minstret[63:32];
            default: w_hit = 1'b0;
        endcase
        for (int k = 0; k < NUM_HPM; k++) begin
            if (csr_addr_i == 12'hB03 + 12'(k)) begin
                w_hit   = 1'b1;
                w_rdata = w_hpm[k][31:0];
            end
            if (csr_addr_i == 12'hB83 + 12'(k)) begin
                w_hit   = 1'b1;
                w_rdata = w_hpm[k][63:32];
            end
        end
    end

    assign csr_illegal_o = csr_req_i & (~w_hit | ((csr_wtype_i != 2'b00) & (csr_addr_i[11:10] == 2'b11)));
    assign csr_rdata_o   = csr_illegal_o ? 32'd0 : w_rdata;
    // Trap and mret take the writeback slot, so a CSR write alongside them is dropped.
    assign w_we = csr_req_i & (csr_wtype_i != 2'b00) & ~csr_illegal_o & ~trap_valid_i & ~mret_i;

    always_comb begin
        case (csr_wtype_i)
            2'b01:   w_wdata = csr_woperand_i;
            2'b10:   w_wdata = w_rdata | csr_woperand_i;
            2'b11:   w_wdata = w_rdata & ~csr_woperand_i;
            default: w_wdata = w_rdata;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'd0;
            r_mtvec        <= 32'd0;
            r_inhibit      <= 32'd0;
            r_mscratch     <= 32'd0;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
            r_mtval        <= 32'd0;
            r_mip          <= 32'd0;
        end else begin
            r_mip <= {20'd0, irq_ext_i, 3'd0, irq_timer_i, 3'd0, irq_soft_i, 3'd0};
            if (trap_valid_i) begin
                r_mepc         <= trap_pc_i & 32'hFFFF_FFFC;
                r_mcause       <= {trap_is_irq_i, trap_cause_i};
                r_mtval        <= trap_tval_i;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (mret_i) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_we) begin
                case (csr_addr_i)
                    12'h300: begin
                        r_mstatus_mie  <= w_wdata[3];
                        r_mstatus_mpie <= w_wdata[7];
                    end
                    12'h304: r_mie      <= w_wdata & 32'h0000_0888;
                    12'h305: r_mtvec    <= w_wdata & MTVEC_MASK;
                    12'h320: r_inhibit  <= w_wdata & INH_MASK;
                    12'h340: r_mscratch <= w_wdata;
                    12'h341: r_mepc     <= w_wdata & 32'hFFFF_FFFC;
                    12'h342: r_mcause   <= w_wdata;
                    12'h343: r_mtval    <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

    // A half-write replaces the increment for that cycle and leaves the other half untouched.
    function automatic logic [63:0] cnt_next(input logic [63:0] cur, input logic wr_lo,
                                             input logic wr_hi, input logic inc, input logic [31:0] wd);
        if (wr_lo)      return {cur[63:32], wd};
        else if (wr_hi) return {wd, cur[31:0]};
        else if (inc)   return cur + 64'd1;
        else            return cur;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            r_mcycle   <= cnt_next(r_mcycle, w_we && csr_addr_i == 12'hB00, w_we && csr_addr_i == 12'hB80,
                                   ~r_inhibit[0], w_wdata);
            r_minstret <= cnt_next(r_minstret, w_we && csr_addr_i == 12'hB02, w_we && csr_addr_i == 12'hB82,
                                   retire_i & ~r_inhibit[2], w_wdata);
        end
    end

    for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
        logic [63:0] r_cnt;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt <= 64'd0;
            end else begin
                r_cnt <= cnt_next(r_cnt, w_we && csr_addr_i == 12'hB03 + 12'(g),
                                  w_we && csr_addr_i == 12'hB83 + 12'(g),
                                  hpm_event_i[g] & ~r_inhibit[3+g], w_wdata) & HPM_MASK;
            end
        end
        assign w_hpm[g] = r_cnt;
    end
    if (NUM_HPM == 0) begin : g_no_hpm
        assign w_hpm[0] = 64'd0;
    end

    assign w_pend    = r_mip & r_mie;
    assign irq_req_o = r_mstatus_mie & (|w_pend);

    always_comb begin
        if (w_pend[11])     irq_cause_o = 31'd11;
        else if (w_pend[3]) irq_cause_o = 31'd3;
        else if (w_pend[7]) irq_cause_o = 31'd7;
        else                irq_cause_o = 31'd0;
    end

`ifdef CSR_VECTORED_MTVEC_EN
    assign trap_handler_addr_o = (r_mtvec[0] & irq_req_o) ? ({r_mtvec[31:2], 2'b00} + {irq_cause_o[29:0], 2'b00})
                                                          : {r_mtvec[31:2], 2'b00};
`else
    assign trap_handler_addr_o = {r_mtvec[31:2], 2'b00};
`endif
    assign mepc_o = r_mepc;

endmodule

// File: tb/tb_csr_file_hpm.sv
// Randomised and directed bench for csr_file_hpm against a CSR-level behavioural model.
module tb_csr_file_hpm;
    localparam int          NH    = 4;
    localparam int          HW    = 40;
    localparam logic [63:0] HMASK = (64'd1 << HW) - 64'd1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        csr_req_i = 1'b0;
    logic [11:0] csr_addr_i = 12'h000;
    logic [1:0]  csr_wtype_i = 2'b00;
    logic [31:0] csr_woperand_i = 32'd0;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        retire_i = 1'b0;
    logic        trap_valid_i = 1'b0;
    logic        trap_is_irq_i = 1'b0;
    logic [30:0] trap_cause_i = 31'd0;
    logic [31:0] trap_pc_i = 32'd0;
    logic [31:0] trap_tval_i = 32'd0;
    logic        mret_i = 1'b0;
    logic [NH-1:0] hpm_event_i = '0;
    logic        irq_ext_i = 1'b0;
    logic        irq_timer_i = 1'b0;
    logic        irq_soft_i = 1'b0;
    logic        irq_req_o;
    logic [30:0] irq_cause_o;
    logic [31:0] trap_handler_addr_o;
    logic [31:0] mepc_o;

    int total = 0;
    int bad   = 0;

    csr_file_hpm #(.NUM_HPM(NH), .HPM_WIDTH(HW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i),
        .csr_wtype_i(csr_wtype_i), .csr_woperand_i(csr_woperand_i), .csr_rdata_o(csr_rdata_o),
        .csr_illegal_o(csr_illegal_o), .retire_i(retire_i), .trap_valid_i(trap_valid_i),
        .trap_is_irq_i(trap_is_irq_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .trap_tval_i(trap_tval_i), .mret_i(mret_i), .hpm_event_i(hpm_event_i),
        .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_soft_i(irq_soft_i),
        .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o),
        .trap_handler_addr_o(trap_handler_addr_o), .mepc_o(mepc_o)
    );

    always #5 clk_i = ~clk_i;

    // Architectural model: each CSR as a plain variable, counters as full 64-bit integers.
    logic [31:0] m_mstatus = 0, m_mie = 0, m_mtvec = 0, m_inh = 0, m_scratch = 0;
    logic [31:0] m_mepc = 0, m_mcause = 0, m_mtval = 0, m_mip = 0;
    logic [63:0] m_cycle = 0, m_instret = 0;
    logic [63:0] m_hpm [NH] = '{default: 64'd0};

    function automatic logic [32:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, m_mstatus};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h320: return {1'b1, m_inh};
            12'h340: return {1'b1, m_scratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, m_mip};
            12'hB00: return {1'b1, m_cycle[31:0]};
            12'hB80: return {1'b1, m_cycle[63:32]};
            12'hB02: return {1'b1, m_instret[31:0]};
            12'hB82: return {1'b1, m_instret[63:32]};
            default: ;
        endcase
        if (a >= 12'hB03 && a < 12'hB03 + NH) return {1'b1, m_hpm[a - 12'hB03][31:0]};
        if (a >= 12'hB83 && a < 12'hB83 + NH) return {1'b1, m_hpm[a - 12'hB83][63:32]};
        return 33'd0;
    endfunction

    function automatic logic m_illegal(input logic req, input logic [11:0] a, input logic [1:0] wt);
        logic [32:0] rr;
        rr = m_read(a);
        return req && (!rr[32] || (wt != 2'b00 && a[11:10] == 2'b11));
    endfunction

    task automatic m_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_inh = 0; m_scratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0; m_cycle = 0; m_instret = 0;
        for (int k = 0; k < NH; k++) m_hpm[k] = 0;
    endtask

    task automatic m_step();
        logic [32:0] rr;
        logic [31:0] wd;
        logic        we;
        logic [63:0] nc, ni;
        logic [63:0] nh [NH];
        rr = m_read(csr_addr_i);
        case (csr_wtype_i)
            2'b01:   wd = csr_woperand_i;
            2'b10:   wd = rr[31:0] | csr_woperand_i;
            2'b11:   wd = rr[31:0] & ~csr_woperand_i;
            default: wd = rr[31:0];
        endcase
        we = csr_req_i && csr_wtype_i != 0 && !m_illegal(csr_req_i, csr_addr_i, csr_wtype_i)
             && !trap_valid_i && !mret_i;
        nc = m_inh[0] ? m_cycle : m_cycle + 1;
        ni = (retire_i && !m_inh[2]) ? m_instret + 1 : m_instret;
        for (int k = 0; k < NH; k++)
            nh[k] = (hpm_event_i[k] && !m_inh[3+k]) ? ((m_hpm[k] + 1) & HMASK) : m_hpm[k];
        if (we) begin
            if (csr_addr_i == 12'hB00) nc = {m_cycle[63:32], wd};
            if (csr_addr_i == 12'hB80) nc = {wd, m_cycle[31:0]};
            if (csr_addr_i == 12'hB02) ni = {m_instret[63:32], wd};
            if (csr_addr_i == 12'hB82) ni = {wd, m_instret[31:0]};
            for (int k = 0; k < NH; k++) begin
                if (csr_addr_i == 12'hB03 + k) nh[k] = {m_hpm[k][63:32], wd} & HMASK;
                if (csr_addr_i == 12'hB83 + k) nh[k] = {wd, m_hpm[k][31:0]} & HMASK;
            end
        end
        if (trap_valid_i) begin
            m_mepc    = trap_pc_i & ~32'h3;
            m_mcause  = {trap_is_irq_i, trap_cause_i};
            m_mtval   = trap_tval_i;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        end else if (mret_i) begin
            m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
        end else if (we) begin
            case (csr_addr_i)
                12'h300: m_mstatus = wd & 32'h88;
                12'h304: m_mie     = wd & 32'h888;
`ifdef CSR_VECTORED_MTVEC_EN
                12'h305: m_mtvec   = wd & ~32'h2;
`else
                12'h305: m_mtvec   = wd & ~32'h3;
`endif
                12'h320: m_inh     = wd & (32'h5 | (((32'd1 << NH) - 1) << 3));
                12'h340: m_scratch = wd;
                12'h341: m_mepc    = wd & ~32'h3;
                12'h342: m_mcause  = wd;
                12'h343: m_mtval   = wd;
                default: ;
            endcase
        end
        m_mip     = (irq_ext_i ? 32'h800 : 0) | (irq_timer_i ? 32'h80 : 0) | (irq_soft_i ? 32'h8 : 0);
        m_cycle   = nc;
        m_instret = ni;
        for (int k = 0; k < NH; k++) m_hpm[k] = nh[k];
    endtask

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) m_reset();
        else       m_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin : compare
        logic [32:0] rr;
        logic        ill;
        logic [31:0] pend;
        logic [30:0] cause;
        logic [31:0] base;
        rr    = m_read(csr_addr_i);
        ill   = m_illegal(csr_req_i, csr_addr_i, csr_wtype_i);
        pend  = m_mip & m_mie & 32'h888;
        cause = pend[11] ? 31'd11 : pend[3] ? 31'd3 : pend[7] ? 31'd7 : 31'd0;
        base  = m_mtvec & ~32'h3;
`ifdef CSR_VECTORED_MTVEC_EN
        if (m_mtvec[0] && m_mstatus[3] && pend != 0) base = base + 4 * cause;
`endif
        chk("rdata", csr_rdata_o, ill ? 32'd0 : rr[31:0]);
        chk("illegal", {31'd0, csr_illegal_o}, {31'd0, ill});
        chk("irq_req", {31'd0, irq_req_o}, {31'd0, m_mstatus[3] && pend != 0});
        chk("irq_cause", {1'b0, irq_cause_o}, {1'b0, cause});
        chk("handler", trap_handler_addr_o, base);
        chk("mepc", mepc_o, m_mepc);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic csr_op(input logic [11:0] a, input logic [1:0] wt, input logic [31:0] op);
        csr_req_i = 1'b1; csr_addr_i = a; csr_wtype_i = wt; csr_woperand_i = op;
        tick();
        csr_req_i = 1'b0; csr_wtype_i = 2'b00;
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        csr_addr_i = a;
        #1;
        chk(nm, csr_rdata_o, exp);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    localparam int NADDR = 26;
    logic [11:0] addrs [NADDR] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03,
                                   12'hB04, 12'hB05, 12'hB06, 12'hB83, 12'hB84, 12'hB85, 12'hB86,
                                   12'hF11, 12'hC00, 12'hB07, 12'h301, 12'h7C0};

    initial begin : stim
        csr_addr_i = 12'hB00;
        #2;
        chk("rst_rdata", csr_rdata_o, 32'd0);
        chk("rst_irq", {31'd0, irq_req_o}, 32'd0);
        chk("rst_handler", trap_handler_addr_o, 32'd0);
        chk("rst_mepc", mepc_o, 32'd0);
        tick();
        rst_i = 1'b0;
        repeat (10) tick();
        rd_chk("mcycle_10", 12'hB00, 32'd10);
        rst_i = 1'b1;
        #1;
        chk("midrst_rdata", csr_rdata_o, 32'd0);
        chk("midrst_irq", {31'd0, irq_req_o}, 32'd0);
        tick();
        rst_i = 1'b0;

        csr_op(12'h340, 2'b01, 32'hA5A5_0000);
        csr_op(12'h340, 2'b10, 32'h0000_00FF);
        csr_op(12'h340, 2'b11, 32'hA500_0000);
        rd_chk("mscratch_ops", 12'h340, 32'h00A5_00FF);

        csr_op(12'hB80, 2'b01, 32'd0);
        csr_op(12'hB00, 2'b01, 32'hFFFF_FFFF);
        rd_chk("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("mcycleh_kept", 12'hB80, 32'd0);
        tick();
        rd_chk("mcycle_wrap", 12'hB00, 32'd0);
        rd_chk("mcycleh_carry", 12'hB80, 32'd1);

        hpm_event_i = 4'b0010;
        repeat (3) tick();
        hpm_event_i = 4'b0000;
        rd_chk("hpm4_count", 12'hB04, 32'd3);
        csr_op(12'h320, 2'b01, 32'h10);
        hpm_event_i = 4'b0010;
        repeat (2) tick();
        hpm_event_i = 4'b0000;
        rd_chk("hpm4_inhibit", 12'hB04, 32'd3);
        csr_op(12'h320, 2'b01, 32'h0);
        csr_op(12'hB84, 2'b01, 32'hFFFF_FFFF);
        rd_chk("hpm4h_trunc", 12'hB84, 32'h0000_00FF);

        csr_op(12'h300, 2'b01, 32'h8);
        trap_valid_i = 1'b1; trap_pc_i = 32'h100; trap_cause_i = 31'd2; trap_tval_i = 32'h1234;
        csr_op(12'h341, 2'b01, 32'h200);
        trap_valid_i = 1'b0;
        #1;
        chk("trap_mepc", mepc_o, 32'h100);
        rd_chk("trap_mcause", 12'h342, 32'd2);
        rd_chk("trap_mstatus", 12'h300, 32'h80);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        rd_chk("mret_mstatus", 12'h300, 32'h88);

        csr_op(12'h304, 2'b01, 32'h888);
        irq_timer_i = 1'b1;
        #1;
        chk("irq_not_yet", {31'd0, irq_req_o}, 32'd0);
        tick();
        chk("irq_timer", {31'd0, irq_req_o}, 32'd1);
        chk("cause_timer", {1'b0, irq_cause_o}, 32'd7);
        irq_ext_i = 1'b1;
        tick();
        chk("cause_ext", {1'b0, irq_cause_o}, 32'd11);
        irq_ext_i = 1'b0; irq_timer_i = 1'b0;
        tick();
        chk("irq_clear", {31'd0, irq_req_o}, 32'd0);

        csr_req_i = 1'b1; csr_addr_i = 12'hF11; csr_wtype_i = 2'b01; csr_woperand_i = 32'hFFFF_FFFF;
        #1;
        chk("illegal_flag", {31'd0, csr_illegal_o}, 32'd1);
        chk("illegal_rdata", csr_rdata_o, 32'd0);
        tick();
        csr_req_i = 1'b0; csr_wtype_i = 2'b00;
        rd_chk("illegal_nochange", 12'h340, 32'h00A5_00FF);

        for (int n = 0; n < 3000; n++) begin
            csr_req_i      = ($urandom_range(0, 3) != 0);
            csr_addr_i     = addrs[$urandom_range(0, NADDR - 1)];
            csr_wtype_i    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       csr_woperand_i = 32'hFFFF_FFFF;
                1:       csr_woperand_i = 32'd0;
                default: csr_woperand_i = $urandom;
            endcase
            retire_i       = 1'($urandom);
            hpm_event_i    = 4'($urandom);
            if ($urandom_range(0, 7) == 0) irq_ext_i   = ~irq_ext_i;
            if ($urandom_range(0, 7) == 0) irq_timer_i = ~irq_timer_i;
            if ($urandom_range(0, 7) == 0) irq_soft_i  = ~irq_soft_i;
            trap_valid_i   = ($urandom_range(0, 15) == 0);
            trap_is_irq_i  = 1'($urandom);
            trap_cause_i   = 31'($urandom);
            trap_pc_i      = $urandom;
            trap_tval_i    = $urandom;
            mret_i         = ($urandom_range(0, 15) == 0);
            tick();
        end
        csr_req_i = 1'b0; csr_wtype_i = 2'b00; trap_valid_i = 1'b0; mret_i = 1'b0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
